// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port DataMemory. Port 0 (CPU) has priority,
// and port 1 (debug/loader) is protected from starvation by a consecutive-grant counter.
module data_mem_arbiter #(
  parameter int unsigned ADDR_LIMIT = 4096,
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic        m0_req_we,
  input  logic [31:0] m0_req_addr,
  input  logic [31:0] m0_req_wdata,
  output logic        m0_rsp_valid,
  output logic [31:0] m0_rsp_rdata,
  output logic        m0_rsp_err,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic        m1_req_we,
  input  logic [31:0] m1_req_addr,
  input  logic [31:0] m1_req_wdata,
  output logic        m1_rsp_valid,
  output logic [31:0] m1_rsp_rdata,
  output logic        m1_rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  // state  | meaning
  // IDLE   | nothing in flight, accept window open
  // ACCESS | latched request drives DataMemory for one cycle
  // RESP   | response pulse to the latched port, accept window open
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0]  MAX_CNT  = 4'(MAX_CONSEC);
  localparam logic [31:0] ADDR_LIM = 32'(ADDR_LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        id_q, id_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic accept_win;
  logic grant0;
  logic grant1;
  logic accept;
  logic legal;

  assign accept_win = (state_q == IDLE) || (state_q == RESP);
  assign grant1     = m1_req_valid && (!m0_req_valid || (cnt_q == MAX_CNT));
  assign grant0     = m0_req_valid && !grant1;
  assign accept     = accept_win && (m0_req_valid || m1_req_valid);
  assign legal      = (addr_q[1:0] == 2'b00) && (addr_q < ADDR_LIM);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: state_d = accept ? ACCESS : IDLE;
      ACCESS:     state_d = RESP;
      default:    state_d = IDLE;
    endcase
  end

  // Request latch, fairness counter and response capture
  always_comb begin
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    if (accept) begin
      id_d    = grant1;
      we_d    = grant1 ? m1_req_we    : m0_req_we;
      addr_d  = grant1 ? m1_req_addr  : m0_req_addr;
      wdata_d = grant1 ? m1_req_wdata : m0_req_wdata;
      if (grant1 || !m1_req_valid) begin
        cnt_d = 4'd0;
      end else if (cnt_q != 4'hF) begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    rsp0_valid_d = (state_q == ACCESS) && !id_q;
    rsp1_valid_d = (state_q == ACCESS) && id_q;
    rsp_rdata_d  = ((state_q == ACCESS) && legal && !we_q) ? mem_read_data : 32'd0;
    rsp_err_d    = (state_q == ACCESS) && !legal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= 4'd0;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_rdata_q  <= 32'd0;
      rsp_err_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Outputs; rst_n gating keeps ready and mem_write quiet while reset is held
  always_comb begin
    m0_req_ready   = rst_n && accept_win && grant0;
    m1_req_ready   = rst_n && accept_win && grant1;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = 32'd0;
    mem_write_data = 32'd0;
    if ((state_q == ACCESS) && legal) begin
      mem_read       = !we_q;
      mem_write      = we_q && rst_n;
      mem_address    = addr_q;
      mem_write_data = we_q ? wdata_q : 32'd0;
    end
    m0_rsp_valid = rsp0_valid_q;
    m0_rsp_rdata = rsp0_valid_q ? rsp_rdata_q : 32'd0;
    m0_rsp_err   = rsp0_valid_q && rsp_err_q;
    m1_rsp_valid = rsp1_valid_q;
    m1_rsp_rdata = rsp1_valid_q ? rsp_rdata_q : 32'd0;
    m1_rsp_err   = rsp1_valid_q && rsp_err_q;
  end

endmodule
